// File: rtl/cpu4_mem_pkg.sv
// Shared definitions for the cpu4 unified memory arbiter: read-owner encoding,
// default bus widths and a counter-width helper.
package cpu4_mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Bits needed to hold 0..max; never less than one bit.
    function automatic int cnt_width(input int max);
        return (max < 2) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/cpu4_sat_cnt.sv
// Saturating up-counter with synchronous clear; sat flags the ceiling.
module cpu4_sat_cnt #(
    parameter int MAX = 3,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    assign sat = (cnt == W'(MAX));

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !sat)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/cpu4_mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and data ports:
// data wins by default, fetch is forced through after MAX_WAIT denied cycles.
module cpu4_mem_arbiter
    import cpu4_mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = cnt_width(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;
    logic             wait_sat;
    logic             wait_inc;
    owner_e           owner_q;

    assign wait_inc = if_req & ~if_gnt;

    cpu4_sat_cnt #(
        .MAX (MAX_WAIT),
        .W   (CNT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wait_inc),
        .clr   (~wait_inc),
        .cnt   (wait_cnt),
        .sat   (wait_sat)
    );

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!reset) begin
            if (if_req && wait_sat)
                if_gnt = 1'b1;
            else if (d_req)
                d_gnt = 1'b1;
            else if (if_req)
                if_gnt = 1'b1;
        end
    end

    always_comb begin
        ram_addr = '0;
        if (d_gnt)
            ram_addr = d_addr;
        else if (if_gnt)
            ram_addr = if_addr;
    end

    assign ram_we    = d_gnt & d_we;
    assign ram_wdata = d_wdata;

    // Owner tags which port the RAM's registered output belongs to next cycle.
    always_ff @(posedge clk) begin
        if (reset)
            owner_q <= OWN_NONE;
        else if (if_gnt)
            owner_q <= OWN_IF;
        else if (d_gnt && !d_we)
            owner_q <= OWN_D;
        else
            owner_q <= OWN_NONE;
    end

    // Gated by reset so a read in flight when reset arrives is dropped at once.
    assign if_rvalid = !reset && (owner_q == OWN_IF);
    assign d_rvalid  = !reset && (owner_q == OWN_D);
    assign if_rdata  = if_rvalid ? ram_rdata : '0;
    assign d_rdata   = d_rvalid  ? ram_rdata : '0;

endmodule

// File: tb/tb_cpu4_mem_arbiter.sv
// Directed-vector and randomized check of cpu4_mem_arbiter against a behavioural RAM.
module tb_cpu4_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;

    logic [31:0] mem [256];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu4_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_WAIT(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    // Single-port RAM with registered read (old data on same-cycle write).
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we)
            mem[ram_addr] = ram_wdata;
    end

    typedef struct {
        logic        ifr;
        logic [7:0]  ifa;
        logic        dr;
        logic        dwe;
        logic [7:0]  da;
        logic [31:0] dwd;
        logic        eig;
        logic        edg;
        logic        ewe;
        logic [7:0]  eaddr;
        logic        eiv;
        logic [31:0] eid;
        logic        edv;
        logic [31:0] edd;
    } vec_t;

    localparam int NV = 15;
    vec_t v [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ifr, input logic [7:0] ifa, input logic dr,
                         input logic dwe, input logic [7:0] da, input logic [31:0] dwd);
        if_req  = ifr;
        if_addr = ifa;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Random-phase state
    int          wcnt;
    logic        ifr_r, dr_r, dwe_r;
    logic [7:0]  ifa_r, da_r;
    logic [31:0] dwd_r;
    logic        exp_if, exp_d, pend_if, pend_d;
    logic [31:0] pend_data;
    logic [7:0]  exp_addr;

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = 32'h100 + i;

        v[0]  = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0,          0, 0};
        v[1]  = '{1, 0, 0, 0, 0, 0,             1, 0, 0, 0, 0, 0,          0, 0};
        v[2]  = '{1, 1, 0, 0, 0, 0,             1, 0, 0, 1, 1, 32'h100,    0, 0};
        v[3]  = '{1, 2, 0, 0, 0, 0,             1, 0, 0, 2, 1, 32'h101,    0, 0};
        v[4]  = '{1, 3, 0, 0, 0, 0,             1, 0, 0, 3, 1, 32'h102,    0, 0};
        v[5]  = '{0, 0, 1, 0, 5, 0,             0, 1, 0, 5, 1, 32'h103,    0, 0};
        v[6]  = '{0, 0, 1, 1, 7, 32'hDEADBEEF,  0, 1, 1, 7, 0, 0,          1, 32'h105};
        v[7]  = '{0, 0, 1, 0, 7, 0,             0, 1, 0, 7, 0, 0,          0, 0};
        v[8]  = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0,          1, 32'hDEADBEEF};
        v[9]  = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0,          0, 0};
        v[10] = '{1, 2, 1, 0, 1, 0,             0, 1, 0, 1, 0, 0,          0, 0};
        v[11] = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0,          1, 32'h101};
        v[12] = '{0, 0, 0, 1, 9, 32'h12345678,  0, 0, 0, 0, 0, 0,          0, 0};
        v[13] = '{1, 4, 0, 1, 9, 32'h5,         1, 0, 0, 4, 0, 0,          0, 0};
        v[14] = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 1, 32'h104,    0, 0};

        // Reset with both requests high: grants must stay low.
        reset = 1'b1;
        drive(1, 8'h3, 1, 1, 8'h4, 32'hA5A5A5A5);
        @(negedge clk);
        chk("rst_if_gnt", 32'(if_gnt), 0);
        chk("rst_d_gnt",  32'(d_gnt),  0);
        chk("rst_ram_we", 32'(ram_we), 0);
        next_cycle();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_rst_if_rvalid", 32'(if_rvalid), 0);
        chk("post_rst_d_rvalid",  32'(d_rvalid),  0);
        chk("post_rst_if_rdata",  if_rdata, 0);
        chk("post_rst_d_rdata",   d_rdata,  0);
        chk("post_rst_ram_addr",  32'(ram_addr), 0);
        next_cycle();

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            drive(v[i].ifr, v[i].ifa, v[i].dr, v[i].dwe, v[i].da, v[i].dwd);
            @(negedge clk);
            chk($sformatf("v%0d_if_gnt", i),    32'(if_gnt),    32'(v[i].eig));
            chk($sformatf("v%0d_d_gnt", i),     32'(d_gnt),     32'(v[i].edg));
            chk($sformatf("v%0d_ram_we", i),    32'(ram_we),    32'(v[i].ewe));
            chk($sformatf("v%0d_ram_addr", i),  32'(ram_addr),  32'(v[i].eaddr));
            chk($sformatf("v%0d_ram_wdata", i), ram_wdata,      v[i].dwd);
            chk($sformatf("v%0d_if_rvalid", i), 32'(if_rvalid), 32'(v[i].eiv));
            chk($sformatf("v%0d_if_rdata", i),  if_rdata,       v[i].eid);
            chk($sformatf("v%0d_d_rvalid", i),  32'(d_rvalid),  32'(v[i].edv));
            chk($sformatf("v%0d_d_rdata", i),   d_rdata,        v[i].edd);
            next_cycle();
        end

        // Contention: data wins three times, then fetch is forced through.
        for (int c = 0; c < 5; c++) begin
            drive(1, 8'h2, 1, 0, 8'h5, 0);
            @(negedge clk);
            chk($sformatf("cont%0d_if_gnt", c), 32'(if_gnt), (c == 3) ? 1 : 0);
            chk($sformatf("cont%0d_d_gnt", c),  32'(d_gnt),  (c == 3) ? 0 : 1);
            chk($sformatf("cont%0d_d_rvalid", c), 32'(d_rvalid), (c >= 1 && c <= 3) ? 1 : 0);
            if (c >= 1 && c <= 3)
                chk($sformatf("cont%0d_d_rdata", c), d_rdata, 32'h105);
            if (c == 4) begin
                chk("cont4_if_rvalid", 32'(if_rvalid), 1);
                chk("cont4_if_rdata",  if_rdata, 32'h102);
                chk("cont4_wait_cnt",  32'(dut.wait_cnt), 0);
            end
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("cont_tail_d_rvalid", 32'(d_rvalid), 1);
        chk("cont_tail_d_rdata",  d_rdata, 32'h105);
        next_cycle();

        // Reset arriving one cycle after a data read grant.
        drive(0, 0, 1, 0, 8'h5, 0);
        @(negedge clk);
        chk("rmr_d_gnt_t", 32'(d_gnt), 1);
        next_cycle();
        reset = 1'b1;
        drive(1, 8'h1, 1, 1, 8'h6, 32'h77);
        @(negedge clk);
        chk("rmr_if_gnt_t1",   32'(if_gnt),   0);
        chk("rmr_d_gnt_t1",    32'(d_gnt),    0);
        chk("rmr_ram_we_t1",   32'(ram_we),   0);
        chk("rmr_d_rvalid_t1", 32'(d_rvalid), 0);
        chk("rmr_d_rdata_t1",  d_rdata, 0);
        next_cycle();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rmr_d_rvalid_t2",  32'(d_rvalid),  0);
        chk("rmr_if_rvalid_t2", 32'(if_rvalid), 0);
        chk("rmr_owner_t2",     32'(dut.owner_q), 0);
        chk("rmr_ram_addr_t2",  32'(ram_addr), 0);
        next_cycle();
        // RAM contents survive reset.
        drive(0, 0, 1, 0, 8'h7, 0);
        @(negedge clk);
        chk("rmr_keep_d_gnt", 32'(d_gnt), 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rmr_keep_d_rvalid", 32'(d_rvalid), 1);
        chk("rmr_keep_d_rdata",  d_rdata, 32'hDEADBEEF);
        next_cycle();

        // Random traffic against a small reference arbiter and scoreboard.
        wcnt    = 0;
        pend_if = 1'b0;
        pend_d  = 1'b0;
        pend_data = '0;
        for (int n = 0; n < 10000; n++) begin
            ifr_r = 1'($urandom_range(0, 1));
            dr_r  = 1'($urandom_range(0, 1));
            dwe_r = 1'($urandom_range(0, 1));
            ifa_r = 8'($urandom_range(0, 15));
            da_r  = 8'($urandom_range(0, 15));
            dwd_r = $urandom;
            drive(ifr_r, ifa_r, dr_r, dwe_r, da_r, dwd_r);
            @(negedge clk);
            exp_if   = ifr_r && (wcnt == 3 || !dr_r);
            exp_d    = dr_r && !exp_if;
            exp_addr = exp_d ? da_r : (exp_if ? ifa_r : 8'h0);
            chk("rnd_excl",     32'(if_gnt & d_gnt), 0);
            chk("rnd_if_gnt",   32'(if_gnt),   32'(exp_if));
            chk("rnd_d_gnt",    32'(d_gnt),    32'(exp_d));
            chk("rnd_ram_we",   32'(ram_we),   32'(exp_d & dwe_r));
            chk("rnd_ram_addr", 32'(ram_addr), 32'(exp_addr));
            chk("rnd_if_rvalid", 32'(if_rvalid), 32'(pend_if));
            chk("rnd_d_rvalid",  32'(d_rvalid),  32'(pend_d));
            if (pend_if) chk("rnd_if_rdata", if_rdata, pend_data);
            if (pend_d)  chk("rnd_d_rdata",  d_rdata,  pend_data);
            pend_if   = exp_if;
            pend_d    = exp_d && !dwe_r;
            pend_data = mem[exp_addr];
            wcnt      = (ifr_r && !exp_if) ? ((wcnt < 3) ? wcnt + 1 : 3) : 0;
            next_cycle();
        end

        // Idle tail: nothing requested, nothing driven.
        drive(0, 0, 0, 0, 0, 0);
        next_cycle();
        @(negedge clk);
        chk("idle_ram_we",    32'(ram_we),    0);
        chk("idle_ram_addr",  32'(ram_addr),  0);
        chk("idle_if_rvalid", 32'(if_rvalid), 0);
        chk("idle_d_rvalid",  32'(d_rvalid),  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
